// File: rtl/seq_divider16.sv
// Restoring sequential unsigned divider, one quotient bit per clock.
// Latency: done WIDTH clocks after the accepting edge, or right after it for a zero divisor.
// Backpressure: start is ignored while busy; results hold until the next completion.
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
  // so after WIDTH steps this register holds the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // One extra bit so the trial subtraction can never overflow.
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic             accept;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  // The remainder MSB is always zero after a step; it exists only as headroom.
  logic             unused_rem_msb;

  assign unused_rem_msb = rem_q[WIDTH];

  // One restoring step: shift in the next dividend bit and try the subtract.
  always_comb begin
    partial   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial     = {1'b0, partial} + {1'b0, ~{1'b0, dvs_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = trial[WIDTH+1];
  end

  // Next-state logic for the FSM, the datapath and the registered outputs.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    accept  = start && (state_q != CALC);

    case (state_q)
      CALC: begin
        rem_d = no_borrow ? trial[WIDTH:0] : partial;
        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = {dvd_q[WIDTH-2:0], no_borrow};
          rmd_d   = no_borrow ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new request in IDLE or DONE takes priority over returning to IDLE.
    if (accept) begin
      dvd_d = dividend;
      dvs_d = divisor;
      rem_d = '0;
      cnt_d = '0;
      if (divisor != '0) begin
        state_d = CALC;
        busy_d  = 1'b1;
        done_d  = 1'b0;
      end else begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        quo_d   = '1;
        rmd_d   = dividend;
        dbz_d   = 1'b1;
      end
    end
  end

  // All state, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
